// File: rtl/acc_breg_ctrl_if.sv
// Command, operand and output-port bundle between acc_breg_ctrl and its
// neighbours: upstream sequencer, adder-subtractor and accumulator consumer.
interface acc_breg_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             CMD_VALID;
   logic             CMD_READY;
   logic [1:0]       CMD_OP;
   logic [WIDTH-1:0] CMD_DATA;
   logic [WIDTH-1:0] ACC_A;
   logic [WIDTH-1:0] ACC_B;
   logic             S_U;
   logic [WIDTH-1:0] SUM;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [WIDTH-1:0] OUT_DATA;
   logic             ZERO;
   logic             NEG;
   logic             BUSY;

   modport slave (
      input  CMD_VALID, CMD_OP, CMD_DATA, SUM, OUT_READY,
      output CMD_READY, ACC_A, ACC_B, S_U, OUT_VALID, OUT_DATA, ZERO, NEG, BUSY
   );

   modport master (
      output CMD_VALID, CMD_OP, CMD_DATA, SUM, OUT_READY,
      input  CMD_READY, ACC_A, ACC_B, S_U, OUT_VALID, OUT_DATA, ZERO, NEG, BUSY
   );
endinterface

// File: rtl/acc_breg_ctrl.sv
// Accumulator / B-register sequencer feeding the SAP-1 adder-subtractor.
// state | meaning
// IDLE  | ready for a command; LDA completes here in one edge
// EXEC  | adder settles on the newly latched B / S_U, no writes
// WB    | SUM written into the accumulator, flags refreshed
// OUTP  | accumulator snapshot offered downstream until OUT_READY
module acc_breg_ctrl #(
   parameter int WIDTH = 8
) (
   input logic            CLK,
   input logic            CLR_n,
   acc_breg_ctrl_if.slave bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_WB   = 2'd2;
   localparam logic [1:0] ST_OUTP = 2'd3;

   localparam logic [1:0] OP_LDA = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_OUT = 2'b11;

   logic [1:0]       state;
   logic [WIDTH-1:0] acc_a;
   logic [WIDTH-1:0] acc_b;
   logic             s_u;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             zero;
   logic             neg;
   logic             cmd_ready;
   logic             cmd_fire;

   assign cmd_ready = (state == ST_IDLE);
   assign cmd_fire  = bus.CMD_VALID && cmd_ready;

   always_ff @(posedge CLK or negedge CLR_n) begin
      if (!CLR_n) begin
         state     <= ST_IDLE;
         acc_a     <= '0;
         acc_b     <= '0;
         s_u       <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         zero      <= 1'b1;
         neg       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_fire) begin
                  case (bus.CMD_OP)
                     OP_LDA: begin
                        acc_a <= bus.CMD_DATA;
                        zero  <= (bus.CMD_DATA == '0);
                        neg   <= bus.CMD_DATA[WIDTH-1];
                     end
                     OP_ADD, OP_SUB: begin
                        acc_b <= bus.CMD_DATA;
                        s_u   <= bus.CMD_OP[1];
                        state <= ST_EXEC;
                     end
                     OP_OUT: begin
                        out_data  <= acc_a;
                        out_valid <= 1'b1;
                        state     <= ST_OUTP;
                     end
                     default: state <= ST_IDLE;
                  endcase
               end
            end
            ST_EXEC: state <= ST_WB;
            // SUM is only sampled here, two edges after B/S_U were latched
            ST_WB: begin
               acc_a <= bus.SUM;
               zero  <= (bus.SUM == '0);
               neg   <= bus.SUM[WIDTH-1];
               state <= ST_IDLE;
            end
            ST_OUTP: begin
               if (bus.OUT_READY) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.CMD_READY = cmd_ready;
   assign bus.BUSY      = !cmd_ready;
   assign bus.ACC_A     = acc_a;
   assign bus.ACC_B     = acc_b;
   assign bus.S_U       = s_u;
   assign bus.OUT_DATA  = out_data;
   assign bus.OUT_VALID = out_valid;
   assign bus.ZERO      = zero;
   assign bus.NEG       = neg;
endmodule

// File: tb/tb_acc_breg_ctrl.sv
// Bench for acc_breg_ctrl: directed scenarios plus random command streams
// compared against a transaction-level accumulator model.
module tb_acc_breg_ctrl;
   localparam int W = 8;

   logic CLK = 1'b0;
   logic CLR_n;
   logic clk_en;
   int   n_chk = 0;
   int   n_pass = 0;

   int m_acc, m_b, m_su, m_out;

   acc_breg_ctrl_if #(.WIDTH(W)) bus ();

   acc_breg_ctrl #(.WIDTH(W)) dut (
      .CLK  (CLK),
      .CLR_n(CLR_n),
      .bus  (bus)
   );

   // behavioural adder-subtractor
   assign bus.SUM = bus.S_U ? (bus.ACC_A - bus.ACC_B) : (bus.ACC_A + bus.ACC_B);

   always begin
      #5;
      if (clk_en) CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_acc = 0; m_b = 0; m_su = 0; m_out = 0;
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_acc"},  32'(bus.ACC_A), 32'(m_acc));
      check({tag, "_b"},    32'(bus.ACC_B), 32'(m_b));
      check({tag, "_su"},   32'(bus.S_U),   32'(m_su));
      check({tag, "_zero"}, 32'(bus.ZERO),  32'(m_acc == 0));
      check({tag, "_neg"},  32'(bus.NEG),   32'((m_acc >> 7) & 1));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_regs(tag);
      check({tag, "_oval"}, 32'(bus.OUT_VALID), 32'd0);
      check({tag, "_odat"}, 32'(bus.OUT_DATA),  32'd0);
      check({tag, "_rdy"},  32'(bus.CMD_READY), 32'd1);
      check({tag, "_busy"}, 32'(bus.BUSY),      32'd0);
   endtask

   task automatic wait_ready();
      int guard = 0;
      while (!bus.CMD_READY && guard < 10) begin
         @(negedge CLK);
         guard++;
      end
      if (!bus.CMD_READY) check("ready_timeout", 32'(bus.CMD_READY), 32'd1);
   endtask

   // issue one command at a negedge and follow it to completion
   task automatic do_cmd(input int op, input int data, input int hold);
      wait_ready();
      bus.CMD_VALID = 1'b1;
      bus.CMD_OP    = 2'(op);
      bus.CMD_DATA  = 8'(data);
      @(negedge CLK);
      bus.CMD_VALID = 1'b0;
      bus.CMD_DATA  = 8'($urandom);
      case (op)
         0: begin
            m_acc = data;
            check_regs("lda");
            check("lda_rdy", 32'(bus.CMD_READY), 32'd1);
         end
         1, 2: begin
            m_b  = data;
            m_su = (op == 2) ? 1 : 0;
            check("as_b",    32'(bus.ACC_B),     32'(m_b));
            check("as_su",   32'(bus.S_U),       32'(m_su));
            check("as_rdy0", 32'(bus.CMD_READY), 32'd0);
            check("as_hold", 32'(bus.ACC_A),     32'(m_acc));
            @(negedge CLK);
            check("exec_busy", 32'(bus.BUSY),  32'd1);
            check("exec_hold", 32'(bus.ACC_A), 32'(m_acc));
            @(negedge CLK);
            if (op == 1) m_acc = (m_acc + data) % 256;
            else         m_acc = (m_acc - data + 256) % 256;
            check_regs("wb");
            check("wb_rdy", 32'(bus.CMD_READY), 32'd1);
         end
         default: begin
            m_out = m_acc;
            for (int i = 0; i < hold; i++) begin
               check("outp_valid", 32'(bus.OUT_VALID), 32'd1);
               check("outp_data",  32'(bus.OUT_DATA),  32'(m_out));
               check("outp_rdy0",  32'(bus.CMD_READY), 32'd0);
               if (i == 0) begin
                  bus.CMD_VALID = 1'b1;
                  bus.CMD_OP    = 2'($urandom_range(0, 2));
                  bus.CMD_DATA  = 8'(~m_acc);
               end
               @(negedge CLK);
            end
            bus.CMD_VALID = 1'b0;
            check("outp_valid_last", 32'(bus.OUT_VALID), 32'd1);
            check("outp_data_last",  32'(bus.OUT_DATA),  32'(m_out));
            bus.OUT_READY = 1'b1;
            @(negedge CLK);
            bus.OUT_READY = 1'b0;
            check("out_done_valid", 32'(bus.OUT_VALID), 32'd0);
            check("out_done_rdy",   32'(bus.CMD_READY), 32'd1);
            check("out_done_data",  32'(bus.OUT_DATA),  32'(m_out));
            check_regs("out_done");
         end
      endcase
   endtask

   function automatic int pick_data();
      case ($urandom_range(0, 5))
         0:       return 0;
         1:       return 255;
         2:       return 128;
         3:       return 1;
         default: return int'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      clk_en        = 1'b0;
      CLR_n         = 1'b1;
      bus.CMD_VALID = 1'b0;
      bus.CMD_OP    = 2'd0;
      bus.CMD_DATA  = '0;
      bus.OUT_READY = 1'b0;
      model_reset();

      // reset with the clock stopped
      #3 CLR_n = 1'b0;
      #1 check_reset_outputs("rst0");
      #1 CLR_n = 1'b1;
      clk_en = 1'b1;
      @(negedge CLK);

      do_cmd(0, 8'h05, 0);
      do_cmd(1, 8'h03, 0);
      check("lda_add_res", 32'(bus.ACC_A), 32'h08);
      do_cmd(2, 8'h0A, 0);
      check("sub_neg_res", 32'(bus.ACC_A), 32'hFE);
      do_cmd(0, 8'hFF, 0);
      do_cmd(1, 8'h01, 0);
      check("wrap_res", 32'(bus.ACC_A), 32'h00);
      do_cmd(0, 8'h2A, 0);
      do_cmd(3, 0, 4);
      do_cmd(3, 0, 0);

      // reset while an ADD sits in EXEC
      do_cmd(0, 8'h10, 0);
      bus.CMD_VALID = 1'b1;
      bus.CMD_OP    = 2'd1;
      bus.CMD_DATA  = 8'h05;
      @(negedge CLK);
      bus.CMD_VALID = 1'b0;
      check("mid_in_exec", 32'(bus.BUSY), 32'd1);
      CLR_n = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("rst_mid");
      @(negedge CLK);
      CLR_n = 1'b1;
      @(negedge CLK);
      check_reset_outputs("rst_mid_after");
      @(negedge CLK);
      check("rst_mid_no_wb", 32'(bus.ACC_A), 32'd0);

      for (int t = 0; t < 80; t++) begin
         do_cmd(int'($urandom_range(0, 3)), pick_data(), int'($urandom_range(0, 4)));
         repeat ($urandom_range(0, 2)) @(negedge CLK);
      end

      // reset with clock stopped while an OUT is pending
      do_cmd(0, 8'h77, 0);
      bus.CMD_VALID = 1'b1;
      bus.CMD_OP    = 2'd3;
      @(negedge CLK);
      bus.CMD_VALID = 1'b0;
      check("outp_pending", 32'(bus.OUT_VALID), 32'd1);
      clk_en = 1'b0;
      #2 CLR_n = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("rst_outp");
      #1 CLR_n = 1'b1;
      clk_en = 1'b1;
      @(negedge CLK);
      do_cmd(2, 8'h01, 0);
      check("post_rst_sub", 32'(bus.ACC_A), 32'hFF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
